led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 112 +++++++++++
 tb/tb_led_pattern_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled multi-mode LED pattern generator; define LED_PATTERN_GEN_PWM_EN for PWM dimming
module led_pattern_gen #(
    parameter int LED_W = 4,
    parameter int DIV_W = 24
) (
    input  logic             pl_clk,
    input  logic             pl_resetn,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
`ifdef LED_PATTERN_GEN_PWM_EN
    input  logic [7:0]       pwm_duty,
`endif
    output logic [LED_W-1:0] led_out,
    output logic             tick
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    localparam logic [LED_W-1:0] TOP_HOT = LED_W'(1) << (LED_W - 1);
    state_t           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d, presc_q, presc_d;
    logic [LED_W-1:0] pat_q, pat_d, bin_q, bin_d, bin_inc, step;
    logic             dir_q, dir_d, step_dir, ready_q, ready_d, accept;
    assign accept    = cfg_valid & ready_q;
    assign cfg_ready = ready_q;
    assign bin_inc   = bin_q + LED_W'(1);
    // an accept pre-empts a pending prescaler-zero step
    assign tick      = (state_q == RUN) & en & ~accept & (presc_q == '0);
    // next pattern (and bounce direction) for the current mode
    always_comb begin
        step     = pat_q;
        step_dir = dir_q;
        case (mode_q)
            3'd1: step = pat_q + LED_W'(1);
            3'd2: step = pat_q - LED_W'(1);
            3'd3: step = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            3'd4: step = {pat_q[0], pat_q[LED_W-1:1]};
            3'd5: begin
                step_dir = dir_q ? ~pat_q[0] : pat_q[LED_W-1];
                step     = step_dir ? pat_q >> 1 : pat_q << 1;
            end
            3'd6: step = bin_inc ^ (bin_inc >> 1);
            default: step = pat_q;
        endcase
    end
    // FSM next state, configuration capture, prescaler and pattern update
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        presc_d = presc_q;
        pat_d   = pat_q;
        bin_d   = bin_q;
        dir_d   = dir_q;
        if (accept) begin
            state_d = LOAD;
            mode_d  = cfg_mode;
            div_d   = cfg_div;
        end else if (state_q == LOAD) begin
            state_d = RUN;
            presc_d = div_q;
            dir_d   = 1'b0;
            bin_d   = '0;
            pat_d   = (mode_q == 3'd3 || mode_q == 3'd5) ? LED_W'(1) :
                      (mode_q == 3'd4) ? TOP_HOT :
                      (mode_q == 3'd0 || mode_q == 3'd7) ? pat_q : '0;
        end else if (tick) begin
            presc_d = div_q;
            pat_d   = step;
            bin_d   = bin_inc;
            dir_d   = step_dir;
        end else if (state_q == RUN && en) begin
            presc_d = presc_q - DIV_W'(1);
        end
        ready_d = (state_d != LOAD);
    end
    // state registers with asynchronous active-low reset
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            state_q <= IDLE;
            mode_q  <= '0;
            div_q   <= '0;
            presc_q <= '0;
            pat_q   <= '0;
            bin_q   <= '0;
            dir_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            presc_q <= presc_d;
            pat_q   <= pat_d;
            bin_q   <= bin_d;
            dir_q   <= dir_d;
            ready_q <= ready_d;
        end
    end
`ifdef LED_PATTERN_GEN_PWM_EN
    logic [7:0] pwm_cnt_q;
    // free-running PWM phase counter
    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) pwm_cnt_q <= '0;
        else            pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
    assign led_out = pat_q & {LED_W{pwm_cnt_q < pwm_duty}};
`else
    assign led_out = pat_q;
`endif
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: table-driven scoreboard bench for led_pattern_gen (LED_W=4)
module tb_led_pattern_gen;
    logic       pl_clk = 1'b0;
    logic       pl_resetn = 1'b0;
    logic       en = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_mode = '0;
    logic [7:0] cfg_div = '0;
    logic [3:0] led_out;
    logic       tick;
    int compared = 0;
    int mismatched = 0;
    logic [3:0] sb [$];

    typedef struct {
        logic [2:0]  mode;
        int          div;
        int          n;
        int          gap_at;
        int          gap_len;
        logic [67:0] seq;
    } vec_t;
    vec_t vt [8];

    led_pattern_gen #(.LED_W(4), .DIV_W(8)) dut (
        .pl_clk(pl_clk), .pl_resetn(pl_resetn), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_div(cfg_div),
        .led_out(led_out), .tick(tick)
    );

    always #5 pl_clk = ~pl_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge pl_clk);
        #1;
    endtask

    task automatic configure(input logic [2:0] mode, input int div);
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_div   = 8'(div);
        @(negedge pl_clk);
        chk("accept_ready", 32'(cfg_ready), 32'd1);
        chk("accept_tick", 32'(tick), 32'd0);
        next_cyc();
        cfg_valid = 1'b0;
        @(negedge pl_clk);
        chk("load_ready", 32'(cfg_ready), 32'd0);
        chk("load_tick", 32'(tick), 32'd0);
        next_cyc();
    endtask

    task automatic run(input int div, input int n, input int gap_at, input int gap_len);
        int phase = 0;
        int ticks = 0;
        int k = 0;
        logic exp_t;
        logic [3:0] exp_led;
        while (ticks < n) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    en = 1'b0;
                    @(negedge pl_clk);
                    chk("gap_tick", 32'(tick), 32'd0);
                    chk("gap_led", 32'(led_out), 32'(sb[0]));
                    next_cyc();
                end
                en = 1'b1;
            end
            @(negedge pl_clk);
            exp_t = (phase == div);
            chk("tick", 32'(tick), 32'(exp_t));
            if (exp_t) begin
                exp_led = sb.pop_front();
                chk("led", 32'(led_out), 32'(exp_led));
                ticks++;
            end
            phase = exp_t ? 0 : phase + 1;
            k++;
            next_cyc();
        end
    endtask

    initial begin
        vt[0] = '{3'd1, 3, 17, -1, 0, 68'h0123456789ABCDEF0};
        vt[1] = '{3'd5, 0,  8, -1, 0, 68'h12484212000000000};
        vt[2] = '{3'd6, 0, 17, -1, 0, 68'h01326754CDFEAB980};
        vt[3] = '{3'd2, 1,  5,  5, 5, 68'h0FEDC000000000000};
        vt[4] = '{3'd3, 2,  5, -1, 0, 68'h12481000000000000};
        vt[5] = '{3'd4, 0,  5, -1, 0, 68'h84218000000000000};
        vt[6] = '{3'd0, 0,  3, -1, 0, 68'h44400000000000000};
        vt[7] = '{3'd7, 1,  3, -1, 0, 68'h44400000000000000};
        // reset state
        @(negedge pl_clk);
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        next_cyc();
        pl_resetn = 1'b1;
        @(negedge pl_clk);
        chk("rel_ready_pre", 32'(cfg_ready), 32'd0);
        next_cyc();
        @(negedge pl_clk);
        chk("rel_ready", 32'(cfg_ready), 32'd1);
        chk("idle_tick", 32'(tick), 32'd0);
        next_cyc();
        // table of modes
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < vt[i].n; j++) sb.push_back(vt[i].seq[(16 - j) * 4 +: 4]);
            configure(vt[i].mode, vt[i].div);
            run(vt[i].div, vt[i].n, vt[i].gap_at, vt[i].gap_len);
        end
        // accept on a prescaler-zero cycle wins over the step
        sb.push_back(4'h1);
        sb.push_back(4'h2);
        configure(3'd3, 2);
        run(2, 2, -1, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge pl_clk);
            chk("pre_zero_tick", 32'(tick), 32'd0);
            next_cyc();
        end
        cfg_valid = 1'b1;
        cfg_mode  = 3'd4;
        cfg_div   = 8'd0;
        @(negedge pl_clk);
        chk("zero_accept_tick", 32'(tick), 32'd0);
        chk("zero_accept_ready", 32'(cfg_ready), 32'd1);
        next_cyc();
        cfg_valid = 1'b0;
        @(negedge pl_clk);
        chk("zero_load_ready", 32'(cfg_ready), 32'd0);
        chk("zero_load_led", 32'(led_out), 32'd4);
        next_cyc();
        @(negedge pl_clk);
        chk("zero_run_led", 32'(led_out), 32'd8);
        chk("zero_run_ready", 32'(cfg_ready), 32'd1);
        chk("zero_run_tick", 32'(tick), 32'd1);
        next_cyc();
        // configuration accepted while en is low, pattern frozen
        en        = 1'b0;
        cfg_valid = 1'b1;
        cfg_mode  = 3'd1;
        cfg_div   = 8'd0;
        @(negedge pl_clk);
        chk("en0_accept_ready", 32'(cfg_ready), 32'd1);
        next_cyc();
        cfg_valid = 1'b0;
        @(negedge pl_clk);
        chk("en0_load_ready", 32'(cfg_ready), 32'd0);
        next_cyc();
        for (int c = 0; c < 4; c++) begin
            @(negedge pl_clk);
            chk("en0_tick", 32'(tick), 32'd0);
            chk("en0_led", 32'(led_out), 32'd0);
            next_cyc();
        end
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge pl_clk);
            chk("en1_tick", 32'(tick), 32'd1);
            chk("en1_led", 32'(led_out), 32'(c));
            next_cyc();
        end
        // asynchronous reset mid-run
        chk("pre_rst_led", 32'(led_out), 32'd3);
        pl_resetn = 1'b0;
        #1;
        chk("arst_led", 32'(led_out), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        next_cyc();
        pl_resetn = 1'b1;
        @(negedge pl_clk);
        chk("arst_rel_ready", 32'(cfg_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            next_cyc();
            @(negedge pl_clk);
            chk("post_rst_ready", 32'(cfg_ready), 32'd1);
            chk("post_rst_led", 32'(led_out), 32'd0);
            chk("post_rst_tick", 32'(tick), 32'd0);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
